// File: rtl/mx11_ins_rom_slave.sv
// mx11_ins_rom_slave: MX bus read slave serving instruction-fetch reads from a
// byte-wide program store. Each transaction: ack, optional wait states before
// every beat, one or more data beats, then a completion pulse.
// Build option: define MXROM_BURST_EN to return BURST_LEN sequential beats per
// transaction; when undefined every transaction returns a single beat and the
// beat counter is not built.
module mx11_ins_rom_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 8,
    parameter int WAIT_STATES = 0,
    parameter int BURST_LEN   = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  ins_rd_txn_start,
    input  logic [ADDR_WIDTH-1:0] ins_rd_addr,
    output logic                  ins_rd_txn_ack,
    output logic                  ins_rd_ready,
    output logic [DATA_WIDTH-1:0] ins_rd_data,
    output logic                  ins_rd_txn_cpl,
    input  logic                  prog_we,
    input  logic [ADDR_WIDTH-1:0] prog_addr,
    input  logic [DATA_WIDTH-1:0] prog_data,
    output logic                  busy
);

    localparam int         DEPTH     = 1 << ADDR_WIDTH;
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES > 0) ? 4'(WAIT_STATES - 1) : 4'd0;

    // Reject out-of-range configurations at elaboration time.
    if (WAIT_STATES < 0 || WAIT_STATES > 15 || BURST_LEN < 1 || BURST_LEN > 16) begin : g_param_err
        $error("mx11_ins_rom_slave: WAIT_STATES must be 0..15 and BURST_LEN 1..16");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_ACK,
        S_WAIT,
        S_DATA,
        S_CPL
    } state_t;

    state_t                  state, state_nxt;
    logic [ADDR_WIDTH-1:0]   cur_addr, addr_nxt;
    logic [3:0]              wait_cnt, wait_nxt;
    logic                    last_beat;
    logic [DATA_WIDTH-1:0]   mem [DEPTH];

`ifdef MXROM_BURST_EN
    localparam logic [3:0] BEATS_INIT = 4'(BURST_LEN - 1);
    logic [3:0] beats_left, beats_nxt;
    assign last_beat = (beats_left == 4'd0);

    // Remaining-beat counter for the active burst.
    always_ff @(posedge clk) begin
        if (rst) beats_left <= 4'd0;
        else     beats_left <= beats_nxt;
    end
`else
    assign last_beat = 1'b1;
`endif

    // State, address and wait-counter registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= S_IDLE;
            cur_addr <= '0;
            wait_cnt <= 4'd0;
        end else begin
            state    <= state_nxt;
            cur_addr <= addr_nxt;
            wait_cnt <= wait_nxt;
        end
    end

    // Next-state logic; addr_nxt is the address the next beat reads from.
    always_comb begin
        state_nxt = state;
        addr_nxt  = cur_addr;
        wait_nxt  = wait_cnt;
`ifdef MXROM_BURST_EN
        beats_nxt = beats_left;
`endif
        case (state)
            S_IDLE: begin
                if (ins_rd_txn_start) begin
                    state_nxt = S_ACK;
                    addr_nxt  = ins_rd_addr;
`ifdef MXROM_BURST_EN
                    beats_nxt = BEATS_INIT;
`endif
                end
            end
            S_ACK: begin
                wait_nxt  = WAIT_INIT;
                state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
            end
            S_WAIT: begin
                if (wait_cnt == 4'd0) state_nxt = S_DATA;
                else                  wait_nxt  = wait_cnt - 4'd1;
            end
            S_DATA: begin
                if (last_beat) begin
                    state_nxt = S_CPL;
                end else begin
                    // Address wraps naturally at the store boundary.
                    addr_nxt  = cur_addr + 1'b1;
                    wait_nxt  = WAIT_INIT;
                    state_nxt = (WAIT_STATES > 0) ? S_WAIT : S_DATA;
`ifdef MXROM_BURST_EN
                    beats_nxt = beats_left - 4'd1;
`endif
                end
            end
            S_CPL:   state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Handshake outputs registered from the upcoming state.
    always_ff @(posedge clk) begin
        if (rst) begin
            ins_rd_txn_ack <= 1'b0;
            ins_rd_ready   <= 1'b0;
            ins_rd_txn_cpl <= 1'b0;
            busy           <= 1'b0;
        end else begin
            ins_rd_txn_ack <= (state_nxt == S_ACK);
            ins_rd_ready   <= (state_nxt == S_DATA);
            ins_rd_txn_cpl <= (state_nxt == S_CPL);
            busy           <= (state_nxt != S_IDLE);
        end
    end

    // Beat data: synchronous read on entry to DATA, held until the next beat.
    always_ff @(posedge clk) begin
        if (rst)                    ins_rd_data <= '0;
        else if (state_nxt == S_DATA) ins_rd_data <= mem[addr_nxt];
    end

    // Program store write port; not reset. Same-edge read sees the old value.
    always_ff @(posedge clk) begin
        if (prog_we) mem[prog_addr] <= prog_data;
    end

endmodule

// File: tb/tb_mx11_ins_rom_slave.sv
// Testbench for mx11_ins_rom_slave: directed scenarios plus random traffic,
// checked every cycle against a timeline model of each transaction.
module tb_mx11_ins_rom_slave;

    localparam int WS = 2;
    localparam int BL = 4;
`ifdef MXROM_BURST_EN
    localparam int NB = BL;
`else
    localparam int NB = 1;
`endif
    localparam int SP      = 1 + WS;                   // cycles between readies
    localparam int CPL_REL = 2 + WS + (NB - 1) * SP + 1; // cpl offset from start

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start = 1'b0;
    logic [7:0] addr = 8'h00;
    logic       we = 1'b0;
    logic [7:0] paddr = 8'h00;
    logic [7:0] pdata = 8'h00;
    logic       ack, ready, cpl, busy;
    logic [7:0] data;

    mx11_ins_rom_slave #(
        .ADDR_WIDTH (8),
        .DATA_WIDTH (8),
        .WAIT_STATES(WS),
        .BURST_LEN  (BL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .ins_rd_txn_start(start),
        .ins_rd_addr     (addr),
        .ins_rd_txn_ack  (ack),
        .ins_rd_ready    (ready),
        .ins_rd_data     (data),
        .ins_rd_txn_cpl  (cpl),
        .prog_we         (we),
        .prog_addr       (paddr),
        .prog_data       (pdata),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    bit         act = 0;
    int         t0 = 0;
    logic [7:0] a0 = 8'h00;
    logic [7:0] exp_data = 8'h00;
    logic [7:0] mm [256];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s cyc=%0d got=%0h exp=%0h", tag, cyc, got, exp);
        end
    endtask

    // Model: a transaction accepted in cycle t0 has ack at t0+1, beat k ready at
    // t0+2+WS+k*SP, cpl right after the last beat, busy from ack through cpl.
    function automatic bit m_busy(input int c);
        return act && (c - t0) >= 1 && (c - t0) <= CPL_REL;
    endfunction

    function automatic bit m_ready(input int c);
        int r;
        r = c - t0 - 2 - WS;
        return act && r >= 0 && (r % SP) == 0 && (r / SP) < NB;
    endfunction

    // Advance one clock: update the model with this cycle's inputs, then check.
    task automatic step();
        logic [7:0] ra;
        @(posedge clk);
        if (rst) begin
            act      = 0;
            exp_data = 8'h00;
        end else if (!m_busy(cyc) && start) begin
            act = 1;
            t0  = cyc;
            a0  = addr;
        end
        cyc++;
        if (!rst && m_ready(cyc)) begin
            ra       = a0 + 8'((cyc - t0 - 2 - WS) / SP);
            exp_data = mm[ra];
        end
        if (we) mm[paddr] = pdata;
        #1;
        chk("ack",   ack,   act && (cyc - t0) == 1);
        chk("ready", ready, m_ready(cyc));
        chk("cpl",   cpl,   act && (cyc - t0) == CPL_REL);
        chk("busy",  busy,  m_busy(cyc));
        chk("data",  data,  exp_data);
    endtask

    task automatic wr(input logic [7:0] a, input logic [7:0] d);
        we = 1'b1; paddr = a; pdata = d;
        step();
        we = 1'b0;
    endtask

    task automatic go(input logic [7:0] a);
        start = 1'b1; addr = a;
        step();
        start = 1'b0;
    endtask

    initial begin
        // Fill the whole store while held in reset.
        for (int i = 0; i < 256; i++) wr(8'(i), 8'($urandom));
        repeat (2) step();
        rst = 1'b0;
        step();

        // Single read of a known value; data must hold after ready drops.
        wr(8'h10, 8'hA5);
        go(8'h10);
        repeat (CPL_REL + 2) step();
        chk("hold_a5", data, 8'hA5);

        // Request during wait states is ignored.
        wr(8'h20, 8'h3C);
        wr(8'h40, 8'h99);
        go(8'h20);
        step();
        go(8'h40);
        repeat (CPL_REL + 2) step();
        go(8'h40);
        repeat (CPL_REL + 2) step();

        // Write colliding with the beat read returns the old value.
        wr(8'h08, 8'h55);
        go(8'h08);
        repeat (WS) step();
        wr(8'h08, 8'h66);
        repeat (CPL_REL + 1) step();
        go(8'h08);
        repeat (CPL_REL + 2) step();
        chk("coll_new", data, 8'h66);

        // Burst across the top of the address space.
        wr(8'hFE, 8'h11); wr(8'hFF, 8'h22); wr(8'h00, 8'h33); wr(8'h01, 8'h44);
        go(8'hFE);
        repeat (CPL_REL + 2) step();

        // Reset right after the second beat (or the only beat).
        go(8'h30);
        repeat (1 + WS + ((NB > 1) ? SP : 0)) step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        repeat (CPL_REL + 2) step();
        go(8'h31);
        repeat (CPL_REL + 2) step();

        // Random traffic: starts, writes near the active address, rare resets.
        for (int n = 0; n < 3000; n++) begin
            start = ($urandom_range(0, 3) == 0);
            addr  = 8'($urandom);
            we    = ($urandom_range(0, 2) == 0);
            paddr = ($urandom_range(0, 1) == 0) ? 8'(a0 + 8'($urandom_range(0, NB))) : 8'($urandom);
            pdata = 8'($urandom);
            rst   = ($urandom_range(0, 199) == 0);
            step();
        end
        start = 1'b0; we = 1'b0; rst = 1'b0;
        repeat (CPL_REL + 2) step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mx11_ins_rom_slave.md
Name: mx11_ins_rom_slave

Overview:
- MX bus read slave for the instruction port; the upstream stage that serves the ins_rd_* transactions issued by the MX11 instruction fetch unit.
- Holds a byte-wide program store, loaded through a simple write port.
- Answers each read transaction with an ack, a programmable number of wait states, one or more data beats, and a completion pulse.

Parameters:
- ADDR_WIDTH, 8, width of ins_rd_addr and prog_addr; store depth is 2**ADDR_WIDTH.
- DATA_WIDTH, 8, width of a store word and of ins_rd_data.
- WAIT_STATES, 0, idle cycles inserted before every data beat (0..15).
- BURST_LEN, 4, beats per transaction when MXROM_BURST_EN is defined (1..16).

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-high reset
- ins_rd_txn_start  in  1  transaction request, sampled only in IDLE
- ins_rd_addr  in  ADDR_WIDTH  start address, latched with txn_start
- ins_rd_txn_ack  out  1  one-cycle acceptance pulse
- ins_rd_ready  out  1  one-cycle strobe; ins_rd_data valid this cycle
- ins_rd_data  out  DATA_WIDTH  beat data
- ins_rd_txn_cpl  out  1  one-cycle completion pulse
- prog_we  in  1  store write enable
- prog_addr  in  ADDR_WIDTH  store write address
- prog_data  in  DATA_WIDTH  store write data
- busy  out  1  high in every state except IDLE

Behaviour:
- Reset state: IDLE; ack, ready, cpl and busy are 0; ins_rd_data is 0; the beat and wait counters are 0.
- Store contents are not cleared by reset.
- FSM states: IDLE, ACK, WAIT, DATA, CPL. All outputs are registered.
- IDLE: if txn_start=1, latch addr into cur_addr, set beats_left = N-1, go to ACK. N is BURST_LEN with burst enabled, otherwise 1.
- ACK: ack=1 for this one cycle. Next state is WAIT if WAIT_STATES>0, otherwise DATA. The wait counter loads WAIT_STATES-1.
- WAIT: decrement the wait counter; go to DATA when it is 0.
- DATA: ready=1 for one cycle; ins_rd_data = store[cur_addr], a synchronous read performed on entry.
  - If beats_left>0: decrement beats_left, cur_addr+1, then go to WAIT (or straight to the next DATA when WAIT_STATES=0).
  - Otherwise go to CPL.
- Address increment wraps modulo 2**ADDR_WIDTH (0xFF -> 0x00 at ADDR_WIDTH=8).
- CPL: cpl=1 for one cycle, then IDLE. A new txn_start is accepted in the IDLE cycle following CPL at the earliest.
- Latency, single beat:
  - txn_start sampled at cycle T.
  - ack at T+1.
  - ready at T+2+WAIT_STATES.
  - cpl at the cycle after the last ready.
- Burst beat spacing: 1+WAIT_STATES cycles between successive ready pulses.
- ins_rd_data holds the last beat value after ready drops, until the next beat or reset.
- txn_start while busy=1 is ignored: not queued, and addr is not relatched. Changes on ins_rd_addr mid-transaction have no effect.
- prog_we is accepted in any state and takes effect at the clock edge.
- Simultaneous write and read of the same address in the cycle the beat is read: read-before-write, so the beat returns the old value.
- rst asserted mid-transaction: the next cycle is IDLE with all outputs 0. No cpl is issued for the aborted transaction.
- At most one of ack, ready, cpl is high in any cycle.

Optional Feature:
- MXROM_BURST_EN defined: each transaction returns BURST_LEN sequential beats.
- Not defined: BURST_LEN is ignored, every transaction returns exactly one beat, and the beat counter logic is removed.
- Handshake ordering (ack, then ready(s), then cpl) is identical in both builds.

Test Plan:
- Single read, no burst, WAIT_STATES=0: program store[0x10]=0xA5; start at cycle 0 with addr=0x10 -> ack cycle 1, ready=1 and data=0xA5 cycle 2, cpl cycle 3, busy low cycle 4.
- Wait states: WAIT_STATES=3, store[0x20]=0x3C, start cycle 0 -> ack cycle 1, ready cycle 5 with data 0x3C, cpl cycle 6.
- Burst with wrap: MXROM_BURST_EN, BURST_LEN=4, WAIT_STATES=0, store[0xFE,0xFF,0x00,0x01]=11,22,33,44, start addr=0xFE -> ready on cycles 2,3,4,5 with data 0x11,0x22,0x33,0x44, cpl cycle 6.
- Ignored request: pulse txn_start with addr=0x40 during the WAIT of an active transaction -> no second ack; the first transaction's data is unchanged; a new start after cpl is served normally.
- Read/write collision: store[0x08]=0x55; prog_we writes 0x66 to 0x08 in the beat-read cycle -> beat data 0x55; the next transaction to 0x08 returns 0x66.
- Reset mid-burst: assert rst after the 2nd ready of a 4-beat burst -> next cycle ack/ready/cpl/busy=0 and data=0, no cpl ever seen; a subsequent transaction completes normally.
